// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I control FSM: decodes state + opcode into datapath strobes,
// handles the memory-ready handshake and halting ECALL, and keeps perf counters.
module multi_cycle_control_unit #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic                 alu_bcond,
  input  logic                 ecall_halt,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_source,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           mem_to_reg,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 is_halted,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_PC4  = 3'd5,
    ST_HALT = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cycle_q, instret_q;

  // NOTE: state registers use non-blocking assignments and a reset sampled on
  // the clock edge, so every flop updates together from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IF;
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q != ST_HALT) cycle_q <= cycle_q + CNT_WIDTH'(1);
      if (state_d == ST_IF && state_q != ST_IF) instret_q <= instret_q + CNT_WIDTH'(1);
    end
  end

  // Reset forces every output low regardless of the (possibly unknown) state.
  assign state       = reset ? 3'd0 : state_q;
  assign cycle_cnt   = reset ? '0 : cycle_q;
  assign instret_cnt = reset ? '0 : instret_q;

  // NOTE: every output and state_d gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    is_halted  = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IF: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            state_d  = ST_ID;
          end
        end
        ST_ID: begin
          alu_src_b = 2'b10;
          case (opcode)
            OP_ECALL: state_d = ecall_halt ? ST_HALT : ST_PC4;
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: state_d = ST_EX;
            default: state_d = ST_PC4;
          endcase
        end
        ST_EX: begin
          state_d = ST_PC4;
          case (opcode)
            OP_R: begin
              alu_src_a = 1'b1; alu_op = 2'b10; state_d = ST_WB;
            end
            OP_I: begin
              alu_src_a = 1'b1; alu_src_b = 2'b10; alu_op = 2'b10; state_d = ST_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_a = 1'b1; alu_src_b = 2'b10; state_d = ST_MEM;
            end
            OP_BRANCH: begin
              alu_src_a = 1'b1; alu_op = 2'b01; pc_source = 1'b1;
              pc_write  = alu_bcond;
              state_d   = alu_bcond ? ST_IF : ST_PC4;
            end
            OP_JAL: begin
              alu_src_b = 2'b01; reg_write = 1'b1; mem_to_reg = 2'b10;
              pc_write  = 1'b1;  pc_source = 1'b1; state_d = ST_IF;
            end
            OP_JALR: begin
              alu_src_a = 1'b1; alu_src_b = 2'b10; state_d = ST_WB;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          i_or_d = 1'b1;
          if (opcode == OP_LOAD) begin
            mem_read = 1'b1;
            if (mem_ready) state_d = ST_WB;
          end else if (opcode == OP_STORE) begin
            mem_write = 1'b1;
            if (mem_ready) begin
              alu_src_b = 2'b01; pc_write = 1'b1; state_d = ST_IF;
            end
          end else begin
            state_d = ST_PC4;
          end
        end
        ST_WB: begin
          state_d = ST_PC4;
          case (opcode)
            OP_R, OP_I, OP_LOAD: begin
              reg_write  = 1'b1;
              mem_to_reg = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
              alu_src_b  = 2'b01; pc_write = 1'b1; state_d = ST_IF;
            end
            OP_JALR: begin
              alu_src_b = 2'b01; reg_write = 1'b1; mem_to_reg = 2'b10;
              pc_write  = 1'b1;  pc_source = 1'b1; state_d = ST_IF;
            end
            default: ;
          endcase
        end
        ST_PC4: begin
          alu_src_b = 2'b01; pc_write = 1'b1; state_d = ST_IF;
        end
        ST_HALT: is_halted = 1'b1;
        default: state_d = ST_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Bench for multi_cycle_control_unit: per-instruction cycle tables built from
// the instruction-level behaviour, driven with random waits and don't-care inputs.
module tb_multi_cycle_control_unit;

  localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3,
                         S_WB = 3'd4, S_PC4 = 3'd5, S_HALT = 3'd6;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_ECALL = 7'b1110011;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw, pcs, iord, mr, mw, irw, rw;
    logic [1:0] m2r;
    logic       a;
    logic [1:0] b, op;
    logic       halted;
  } exp_t;

  typedef struct {
    exp_t       e;
    logic [6:0] opc;
    logic       rdy, bc, eh, last;
  } step_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = '0;
  logic alu_bcond = 1'b0, ecall_halt = 1'b0, mem_ready = 1'b0;

  logic pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write, alu_src_a, is_halted;
  logic [1:0] mem_to_reg, alu_src_b, alu_op;
  logic [2:0] state;
  logic [31:0] cycle_cnt, instret_cnt;

  logic pc_write4, pc_source4, i_or_d4, mem_read4, mem_write4, ir_write4, reg_write4, alu_src_a4, is_halted4;
  logic [1:0] mem_to_reg4, alu_src_b4, alu_op4;
  logic [2:0] state4;
  logic [3:0] cycle_cnt4, instret_cnt4;

  exp_t act, act4;
  assign act  = {state, pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, is_halted};
  assign act4 = {state4, pc_write4, pc_source4, i_or_d4, mem_read4, mem_write4, ir_write4, reg_write4,
                 mem_to_reg4, alu_src_a4, alu_src_b4, alu_op4, is_halted4};

  multi_cycle_control_unit dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .ecall_halt(ecall_halt),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_source(pc_source), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .is_halted(is_halted), .state(state), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  multi_cycle_control_unit #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_bcond(alu_bcond), .ecall_halt(ecall_halt),
    .mem_ready(mem_ready), .pc_write(pc_write4), .pc_source(pc_source4), .i_or_d(i_or_d4),
    .mem_read(mem_read4), .mem_write(mem_write4), .ir_write(ir_write4), .reg_write(reg_write4),
    .mem_to_reg(mem_to_reg4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
    .is_halted(is_halted4), .state(state4), .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
  );

  always #5 clk = ~clk;

  step_t q[$];
  int n_checks = 0, n_errors = 0;
  int unsigned exp_cycles = 0, exp_instret = 0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t ph(input logic [2:0] st);
    exp_t e = '0;
    e.st = st;
    e.halted = (st == S_HALT);
    return e;
  endfunction

  // PC <= PC + 4 through the combinational ALU path.
  function automatic exp_t pc4(input exp_t e);
    e.b = 2'b01;
    e.pcw = 1'b1;
    return e;
  endfunction

  task automatic push(input exp_t e, input logic [6:0] opc, input logic rdy, bc, eh, last);
    step_t s;
    s.e = e; s.opc = opc; s.rdy = rdy; s.bc = bc; s.eh = eh; s.last = last;
    q.push_back(s);
  endtask

  task automatic build(input logic [6:0] opc, input int if_w, mem_w, input logic bc, eh);
    exp_t e;
    for (int i = 0; i < if_w; i++) begin
      e = ph(S_IF); e.mr = 1'b1;
      push(e, 7'($urandom), 1'b0, rb(), rb(), 1'b0);
    end
    e = ph(S_IF); e.mr = 1'b1; e.irw = 1'b1;
    push(e, 7'($urandom), 1'b1, rb(), rb(), 1'b0);
    e = ph(S_ID); e.b = 2'b10;
    push(e, opc, rb(), rb(), (opc == OP_ECALL) ? eh : rb(), 1'b0);
    case (opc)
      OP_R, OP_I: begin
        e = ph(S_EX); e.a = 1'b1; e.op = 2'b10; e.b = (opc == OP_I) ? 2'b10 : 2'b00;
        push(e, opc, rb(), rb(), rb(), 1'b0);
        e = pc4(ph(S_WB)); e.rw = 1'b1;
        push(e, opc, rb(), rb(), rb(), 1'b1);
      end
      OP_LOAD, OP_STORE: begin
        e = ph(S_EX); e.a = 1'b1; e.b = 2'b10;
        push(e, opc, rb(), rb(), rb(), 1'b0);
        e = ph(S_MEM); e.iord = 1'b1; e.mr = (opc == OP_LOAD); e.mw = (opc == OP_STORE);
        for (int i = 0; i < mem_w; i++) push(e, opc, 1'b0, rb(), rb(), 1'b0);
        if (opc == OP_STORE) begin
          push(pc4(e), opc, 1'b1, rb(), rb(), 1'b1);
        end else begin
          push(e, opc, 1'b1, rb(), rb(), 1'b0);
          e = pc4(ph(S_WB)); e.rw = 1'b1; e.m2r = 2'b01;
          push(e, opc, rb(), rb(), rb(), 1'b1);
        end
      end
      OP_BR: begin
        e = ph(S_EX); e.a = 1'b1; e.op = 2'b01; e.pcs = 1'b1; e.pcw = bc;
        push(e, opc, rb(), bc, rb(), bc);
        if (!bc) push(pc4(ph(S_PC4)), opc, rb(), rb(), rb(), 1'b1);
      end
      OP_JAL: begin
        e = pc4(ph(S_EX)); e.rw = 1'b1; e.m2r = 2'b10; e.pcs = 1'b1;
        push(e, opc, rb(), rb(), rb(), 1'b1);
      end
      OP_JALR: begin
        e = ph(S_EX); e.a = 1'b1; e.b = 2'b10;
        push(e, opc, rb(), rb(), rb(), 1'b0);
        e = pc4(ph(S_WB)); e.rw = 1'b1; e.m2r = 2'b10; e.pcs = 1'b1;
        push(e, opc, rb(), rb(), rb(), 1'b1);
      end
      OP_ECALL: if (!eh) push(pc4(ph(S_PC4)), opc, rb(), rb(), rb(), 1'b1);
      default: push(pc4(ph(S_PC4)), opc, rb(), rb(), rb(), 1'b1);
    endcase
  endtask

  // Drives up to n queued cycles (n < 0: all), checking outputs and counters each cycle.
  task automatic run_steps(input int n);
    step_t s;
    int done = 0;
    while (q.size() > 0 && (n < 0 || done < n)) begin
      s = q.pop_front();
      opcode = s.opc; mem_ready = s.rdy; alu_bcond = s.bc; ecall_halt = s.eh;
      #1;
      n_checks++;
      if (act !== s.e) begin
        n_errors++;
        $display("FAIL outputs t=%0t got %h expected %h", $time, act, s.e);
      end
      n_checks++;
      if (act4 !== s.e) begin
        n_errors++;
        $display("FAIL outputs_w4 t=%0t got %h expected %h", $time, act4, s.e);
      end
      n_checks++;
      if (cycle_cnt !== exp_cycles || cycle_cnt4 !== exp_cycles[3:0]) begin
        n_errors++;
        $display("FAIL cycle_cnt t=%0t got %0d/%0d expected %0d/%0d", $time, cycle_cnt, cycle_cnt4,
                 exp_cycles, exp_cycles[3:0]);
      end
      n_checks++;
      if (instret_cnt !== exp_instret || instret_cnt4 !== exp_instret[3:0]) begin
        n_errors++;
        $display("FAIL instret_cnt t=%0t got %0d/%0d expected %0d/%0d", $time, instret_cnt,
                 instret_cnt4, exp_instret, exp_instret[3:0]);
      end
      @(posedge clk); #1;
      if (s.e.st != S_HALT) exp_cycles++;
      if (s.last) exp_instret++;
      done++;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      opcode = 7'($urandom); mem_ready = rb(); alu_bcond = rb(); ecall_halt = rb();
      #1;
      n_checks++;
      if ({act, act4, cycle_cnt, instret_cnt, cycle_cnt4, instret_cnt4} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs t=%0t got %h/%h cnt %0d/%0d expected all 0", $time, act, act4,
                 cycle_cnt, instret_cnt);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    exp_cycles = 0;
    exp_instret = 0;
  endtask

  task automatic test_reset;
    do_reset(3);
    build(OP_R, 0, 0, 1'b0, 1'b0);
    run_steps(-1);
    #1;
    n_checks++;
    if (state !== S_IF || cycle_cnt !== 32'd4 || instret_cnt !== 32'd1) begin
      n_errors++;
      $display("FAIL after_first_r state=%0d cycle=%0d instret=%0d expected 0/4/1", state, cycle_cnt,
               instret_cnt);
    end
  endtask

  task automatic test_load_waits;
    build(OP_LOAD, 2, 2, 1'b0, 1'b0);
    n_checks++;
    if (q.size() != 9) begin
      n_errors++;
      $display("FAIL load_len got %0d expected 9", q.size());
    end
    run_steps(-1);
  endtask

  task automatic test_branch;
    build(OP_BR, 0, 0, 1'b1, 1'b0);
    build(OP_BR, 0, 0, 1'b0, 1'b0);
    run_steps(-1);
  endtask

  task automatic test_jal_jalr;
    build(OP_JAL, 0, 0, 1'b0, 1'b0);
    build(OP_JALR, 1, 0, 1'b0, 1'b0);
    build(OP_STORE, 1, 1, 1'b0, 1'b0);
    run_steps(-1);
  endtask

  task automatic test_ecall;
    build(OP_ECALL, 1, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) push(ph(S_HALT), 7'($urandom), rb(), rb(), rb(), 1'b0);
    run_steps(-1);
    do_reset(1);
    build(OP_ECALL, 0, 0, 1'b0, 1'b0);
    build(7'b0000000, 0, 0, 1'b0, 1'b0);
    run_steps(-1);
  endtask

  task automatic test_reset_abort;
    build(OP_STORE, 0, 3, 1'b0, 1'b0);
    run_steps(4);
    q.delete();
    do_reset(1);
    build(OP_JAL, 0, 0, 1'b0, 1'b0);
    run_steps(-1);
  endtask

  task automatic test_random;
    logic [6:0] ops [9];
    logic [6:0] opc;
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_ECALL, 7'b0};
    for (int n = 0; n < 60; n++) begin
      opc = ops[$urandom_range(0, 8)];
      if (opc == 7'b0) begin
        do opc = 7'($urandom);
        while (opc inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR, OP_ECALL});
      end
      build(opc, $urandom_range(0, 2), $urandom_range(0, 2), rb(), 1'b0);
      run_steps(-1);
    end
  endtask

  initial begin
    test_reset();
    test_load_waits();
    test_branch();
    test_jal_jalr();
    test_ecall();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
